rip_csr_unit: RTL and testbench

- Machine-mode CSR unit. It replaces the flat 4096-entry CSR array with a sparse, decoded set of architectural M-mode CSRs.
- Adds WARL masking, read-only and illegal-address detection, 64-bit cycle/instret counters, and trap entry/mret side effects.
- Sits beside the execute stage: receives decoded CSR ops plus trap/retire events from the pipeline, and feeds mtvec/mepc/interrupt-pending back to fetch.

---
 rtl/rip_csr_pkg.sv | 65 ++++++
 rtl/rip_csr_if.sv | 28 ++
 rtl/rip_csr_counter.sv | 29 ++
 rtl/rip_csr_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_rip_csr_unit.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rip_csr_pkg.sv
// rip_csr_pkg: shared types and constants for the machine-mode CSR unit.
// Holds the CSR operation encoding, the decoded CSR address map, mstatus
// field positions and the WARL write masks applied after each update.
package rip_csr_pkg;

  typedef enum logic [2:0] {
    CSR_NONE  = 3'd0,
    CSR_READ  = 3'd1,
    CSR_WRITE = 3'd2,
    CSR_SET   = 3'd3,
    CSR_CLEAR = 3'd4
  } csr_op_t;

  // Machine trap setup / handling
  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;

  // Machine counters and their user-level read-only shadows
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // MPP is hardwired to machine mode
  localparam logic [31:0] MSTATUS_MPP_RO = 32'h0000_1800;

  // WARL write masks, applied to the result of WRITE/SET/CLEAR
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] FULL_WMASK    = 32'hFFFF_FFFF;

  // Read-modify-write result of a CSR op against the current value
  function automatic logic [31:0] csr_apply(input csr_op_t op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] opnd);
    case (op)
      CSR_WRITE: return opnd;
      CSR_SET:   return old_val | opnd;
      CSR_CLEAR: return old_val & ~opnd;
      default:   return old_val;
    endcase
  endfunction

endpackage

// File: rtl/rip_csr_if.sv
// rip_csr_if: decoded CSR access port between the execute stage (master)
// and the CSR unit (slave). Read data and the illegal flag are registered
// by the slave and valid one cycle after the op is presented.
interface rip_csr_if #(
  parameter int XLEN = 32
);
  logic [2:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_din;
  logic [XLEN-1:0] csr_dout;
  logic            csr_illegal;

  modport master (
    output csr_op,
    output csr_addr,
    output csr_din,
    input  csr_dout,
    input  csr_illegal
  );

  modport slave (
    input  csr_op,
    input  csr_addr,
    input  csr_din,
    output csr_dout,
    output csr_illegal
  );
endinterface

// File: rtl/rip_csr_counter.sv
// rip_csr_counter: CNT_W-bit free-running counter with increment enable and
// independent 32-bit write ports for the low and high halves. Used for
// mcycle and (optionally) minstret.
module rip_csr_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] count
);

  // A write to either half wins over the increment; the untouched half
  // keeps its value, so no carry propagates in a write cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]       <= wdata;
      if (wr_hi) count[CNT_W-1:32] <= wdata[CNT_W-33:0];
    end else if (inc_en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rip_csr_unit.sv
// rip_csr_unit: machine-mode CSR unit with a sparse decoded register set.
// Provides WARL masking, read-only/illegal-address detection, 64-bit
// cycle/instret counters and trap-entry / mret side effects on mstatus,
// mepc, mcause and mtval. Reads return the pre-update value one cycle later.
//
// Build option: define RIP_CSR_MINSTRET_EN to implement minstret/instret.
// Without it the instret addresses stay legal, read 0, drop writes, and the
// retire input is ignored.
module rip_csr_unit
  import rip_csr_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] HART_ID  = 32'h0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100,
  parameter int          CNT_W    = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  rip_csr_if.slave        bus,
  input  logic            retire,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_soft,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_pending
);

  csr_op_t     op;
  logic        op_active;
  logic        op_modify;
  logic        addr_hit;
  logic        acc_illegal;
  logic        do_write;
  logic [31:0] rd_val;
  logic [31:0] wr_val;

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mstatus_val;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [31:0] mip_val;

  logic [CNT_W-1:0] mcycle_cnt;
  logic [63:0]      cycle64;
  logic [63:0]      instret64;

  logic we_mstatus, we_mie, we_mtvec, we_mscratch;
  logic we_mepc, we_mcause, we_mtval;
  logic we_mcycle, we_mcycleh;

  // Classify the incoming op; undefined encodings behave as NONE
  always_comb begin
    op        = csr_op_t'(bus.csr_op);
    op_active = 1'b0;
    op_modify = 1'b0;
    case (op)
      CSR_READ: op_active = 1'b1;
      CSR_WRITE, CSR_SET, CSR_CLEAR: begin
        op_active = 1'b1;
        op_modify = 1'b1;
      end
      default: ;
    endcase
  end

  // Live views of mstatus and mip
  always_comb begin
    mstatus_val               = MSTATUS_MPP_RO;
    mstatus_val[MSTATUS_MIE]  = mstatus_mie;
    mstatus_val[MSTATUS_MPIE] = mstatus_mpie;
    mip_val                   = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_soft, 3'b0};
  end

  assign cycle64 = 64'(mcycle_cnt);

  // Address decode and read mux (pre-update value of the addressed CSR)
  always_comb begin
    rd_val   = '0;
    addr_hit = 1'b1;
    case (bus.csr_addr)
      ADDR_MSTATUS:                 rd_val = mstatus_val;
      ADDR_MISA:                    rd_val = MISA_VAL;
      ADDR_MIE:                     rd_val = mie_q;
      ADDR_MTVEC:                   rd_val = mtvec_q;
      ADDR_MSCRATCH:                rd_val = mscratch_q;
      ADDR_MEPC:                    rd_val = mepc_q;
      ADDR_MCAUSE:                  rd_val = mcause_q;
      ADDR_MTVAL:                   rd_val = mtval_q;
      ADDR_MIP:                     rd_val = mip_val;
      ADDR_MCYCLE,   ADDR_CYCLE:    rd_val = cycle64[31:0];
      ADDR_MCYCLEH,  ADDR_CYCLEH:   rd_val = cycle64[63:32];
      ADDR_MINSTRET, ADDR_INSTRET:  rd_val = instret64[31:0];
      ADDR_MINSTRETH,ADDR_INSTRETH: rd_val = instret64[63:32];
      ADDR_MHARTID:                 rd_val = HART_ID;
      default:                      addr_hit = 1'b0;
    endcase
  end

  // Unimplemented addresses, and modifying ops on the read-only 0xC00-0xFFF
  // quadrant, are illegal and leave all state untouched.
  assign acc_illegal = op_active & (~addr_hit | (op_modify & (bus.csr_addr[11:10] == 2'b11)));
  assign do_write    = op_modify & ~acc_illegal;
  assign wr_val      = csr_apply(op, rd_val, bus.csr_din);

  assign we_mstatus  = do_write & (bus.csr_addr == ADDR_MSTATUS);
  assign we_mie      = do_write & (bus.csr_addr == ADDR_MIE);
  assign we_mtvec    = do_write & (bus.csr_addr == ADDR_MTVEC);
  assign we_mscratch = do_write & (bus.csr_addr == ADDR_MSCRATCH);
  assign we_mepc     = do_write & (bus.csr_addr == ADDR_MEPC);
  assign we_mcause   = do_write & (bus.csr_addr == ADDR_MCAUSE);
  assign we_mtval    = do_write & (bus.csr_addr == ADDR_MTVAL);
  assign we_mcycle   = do_write & (bus.csr_addr == ADDR_MCYCLE);
  assign we_mcycleh  = do_write & (bus.csr_addr == ADDR_MCYCLEH);

  // Registered read data and one-cycle illegal pulse; NONE holds csr_dout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.csr_dout    <= '0;
      bus.csr_illegal <= 1'b0;
    end else begin
      bus.csr_illegal <= acc_illegal;
      if (op_active) bus.csr_dout <= acc_illegal ? '0 : rd_val;
    end
  end

  // mstatus: trap entry beats mret, and both beat a CSR write to MIE/MPIE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (we_mstatus) begin
      mstatus_mie  <= wr_val[MSTATUS_MIE];
      mstatus_mpie <= wr_val[MSTATUS_MPIE];
    end
  end

  // Trap-captured registers: trap entry overrides any same-cycle CSR write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (trap) begin
      mepc_q   <= trap_pc & MEPC_WMASK;
      mcause_q <= trap_cause;
      mtval_q  <= trap_val;
    end else begin
      if (we_mepc)   mepc_q   <= wr_val & MEPC_WMASK;
      if (we_mcause) mcause_q <= wr_val;
      if (we_mtval)  mtval_q  <= wr_val;
    end
  end

  // Plain software-written registers, unaffected by trap/mret
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
    end else begin
      if (we_mie)      mie_q      <= wr_val & MIE_WMASK;
      if (we_mtvec)    mtvec_q    <= wr_val & MTVEC_WMASK;
      if (we_mscratch) mscratch_q <= wr_val & FULL_WMASK;
    end
  end

  rip_csr_counter #(.CNT_W(CNT_W)) u_mcycle (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (1'b1),
    .wr_lo  (we_mcycle),
    .wr_hi  (we_mcycleh),
    .wdata  (wr_val),
    .count  (mcycle_cnt)
  );

`ifdef RIP_CSR_MINSTRET_EN
  logic [CNT_W-1:0] minstret_cnt;
  logic             we_minstret;
  logic             we_minstreth;

  assign we_minstret  = do_write & (bus.csr_addr == ADDR_MINSTRET);
  assign we_minstreth = do_write & (bus.csr_addr == ADDR_MINSTRETH);

  rip_csr_counter #(.CNT_W(CNT_W)) u_minstret (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (retire),
    .wr_lo  (we_minstret),
    .wr_hi  (we_minstreth),
    .wdata  (wr_val),
    .count  (minstret_cnt)
  );

  assign instret64 = 64'(minstret_cnt);
`else
  logic unused_retire;

  assign instret64     = '0;
  assign unused_retire = retire;
`endif

  assign mtvec_o     = mtvec_q;
  assign mepc_o      = mepc_q;
  assign irq_pending = mstatus_mie & (|(mie_q & mip_val));

endmodule

// File: tb/tb_rip_csr_unit.sv
// tb_rip_csr_unit: self-checking bench for rip_csr_unit. A table of directed
// vectors, hand-written multi-cycle sequences (counter carry, trap/mret,
// reset mid-op) and a randomized run, all checked against a CSR model kept
// as an address-indexed map plus 64-bit counters.
module tb_rip_csr_unit;
  import rip_csr_pkg::*;

`ifdef RIP_CSR_MINSTRET_EN
  localparam bit INS_EN = 1'b1;
`else
  localparam bit INS_EN = 1'b0;
`endif
  localparam logic [31:0] MISA_V = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        retire, trap, mret;
  logic [31:0] trap_cause, trap_pc, trap_val;
  logic        irq_ext, irq_timer, irq_soft;
  logic [31:0] mtvec_o, mepc_o;
  logic        irq_pending;

  rip_csr_if #(.XLEN(32)) bus ();

  rip_csr_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .retire     (retire),
    .trap       (trap),
    .trap_cause (trap_cause),
    .trap_pc    (trap_pc),
    .trap_val   (trap_val),
    .mret       (mret),
    .irq_ext    (irq_ext),
    .irq_timer  (irq_timer),
    .irq_soft   (irq_soft),
    .mtvec_o    (mtvec_o),
    .mepc_o     (mepc_o),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_csr [logic [11:0]];
  logic [63:0] m_cyc, m_ins;
  logic [31:0] m_dout;
  logic        m_ill;
  logic        m_irq;

  function automatic logic [31:0] wmask(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_0088;
      12'h304: return 32'h0000_0888;
      12'h305: return 32'hFFFF_FFFD;
      12'h341: return 32'hFFFF_FFFC;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] mip_now();
    return {20'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_soft, 3'd0};
  endfunction

  function automatic bit m_lookup(input logic [11:0] a, output logic [31:0] v);
    v = 32'd0;
    if (m_csr.exists(a)) begin
      v = m_csr[a];
      if (a == 12'h300) v = v | 32'h0000_1800;
      return 1'b1;
    end
    case (a)
      12'h301:          v = MISA_V;
      12'h344:          v = mip_now();
      12'hF14:          v = 32'd0;
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ins[31:0];
      12'hB82, 12'hC82: v = m_ins[63:32];
      default:          return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_csr.delete();
    m_csr[12'h300] = 0; m_csr[12'h304] = 0; m_csr[12'h305] = 0;
    m_csr[12'h340] = 0; m_csr[12'h341] = 0; m_csr[12'h342] = 0; m_csr[12'h343] = 0;
    m_cyc = 0; m_ins = 0; m_dout = 0; m_ill = 0; m_irq = 0;
  endtask

  task automatic model_step(input logic [2:0] op, input logic [11:0] a, input logic [31:0] din);
    logic [31:0] old_v, nv, mst;
    bit impl, active, modify, bad, cyc_wr, ins_wr;
    active = (op >= 3'd1) && (op <= 3'd4);
    modify = (op >= 3'd2) && (op <= 3'd4);
    impl   = m_lookup(a, old_v);
    bad    = active && (!impl || (modify && a[11:10] == 2'b11));
    cyc_wr = 0;
    ins_wr = 0;
    if (active) m_dout = bad ? 32'd0 : old_v;
    m_ill = bad;
    if (modify && !bad) begin
      if (op == CSR_WRITE)    nv = din;
      else if (op == CSR_SET) nv = old_v | din;
      else                    nv = old_v & ~din;
      case (a)
        12'hB00: begin m_cyc[31:0]  = nv; cyc_wr = 1; end
        12'hB80: begin m_cyc[63:32] = nv; cyc_wr = 1; end
        12'hB02: if (INS_EN) begin m_ins[31:0]  = nv; ins_wr = 1; end
        12'hB82: if (INS_EN) begin m_ins[63:32] = nv; ins_wr = 1; end
        default: if (m_csr.exists(a)) begin
          if (!(trap && (a == 12'h300 || a == 12'h341 || a == 12'h342 || a == 12'h343)) &&
              !(mret && a == 12'h300))
            m_csr[a] = nv & wmask(a);
        end
      endcase
    end
    if (!cyc_wr) m_cyc = m_cyc + 64'd1;
    if (INS_EN && retire && !ins_wr) m_ins = m_ins + 64'd1;
    if (trap) begin
      mst = m_csr[12'h300];
      m_csr[12'h341] = trap_pc & 32'hFFFF_FFFC;
      m_csr[12'h342] = trap_cause;
      m_csr[12'h343] = trap_val;
      m_csr[12'h300] = mst[3] ? 32'h80 : 32'h0;
    end else if (mret) begin
      mst = m_csr[12'h300];
      m_csr[12'h300] = 32'h80 | (mst[7] ? 32'h8 : 32'h0);
    end
    mst   = m_csr[12'h300];
    m_irq = mst[3] && ((m_csr[12'h304] & mip_now()) != 0);
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive op, advance the model, compare after the edge
  task automatic step(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d);
    bus.csr_op   = op;
    bus.csr_addr = a;
    bus.csr_din  = d;
    model_step(op, a, d);
    @(posedge clk);
    #1;
    chk("csr_dout",    bus.csr_dout,            m_dout);
    chk("csr_illegal", {31'd0, bus.csr_illegal}, {31'd0, m_ill});
    chk("mtvec_o",     mtvec_o,                 m_csr[12'h305]);
    chk("mepc_o",      mepc_o,                  m_csr[12'h341]);
    chk("irq_pending", {31'd0, irq_pending},    {31'd0, m_irq});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " dout"},    bus.csr_dout,            32'd0);
    chk({tag, " illegal"}, {31'd0, bus.csr_illegal}, 32'd0);
    chk({tag, " mtvec_o"}, mtvec_o,                 32'd0);
    chk({tag, " mepc_o"},  mepc_o,                  32'd0);
    chk({tag, " irq"},     {31'd0, irq_pending},    32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_ill;
  } vec_t;

  vec_t vt[23];

  logic [11:0] addr_pool[22] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14,
                                 12'h7C0, 12'hF11, 12'h000, 12'h3A0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{CSR_READ,  12'h300, 32'h0,          32'h0000_1800, 1'b0};
    vt[1]  = '{CSR_READ,  12'hF14, 32'h0,          32'h0000_0000, 1'b0};
    vt[2]  = '{CSR_WRITE, 12'h340, 32'hDEAD_BEEF,  32'h0000_0000, 1'b0};
    vt[3]  = '{CSR_SET,   12'h340, 32'h0000_000F,  32'hDEAD_BEEF, 1'b0};
    vt[4]  = '{CSR_CLEAR, 12'h340, 32'hFFFF_0000,  32'hDEAD_BEEF, 1'b0};
    vt[5]  = '{CSR_READ,  12'h340, 32'h0,          32'h0000_BEEF, 1'b0};
    vt[6]  = '{CSR_WRITE, 12'hC00, 32'h5,          32'h0000_0000, 1'b1};
    vt[7]  = '{CSR_READ,  12'h7C0, 32'h0,          32'h0000_0000, 1'b1};
    vt[8]  = '{CSR_WRITE, 12'h344, 32'hFFFF_FFFF,  32'h0000_0000, 1'b0};
    vt[9]  = '{CSR_READ,  12'h344, 32'h0,          32'h0000_0000, 1'b0};
    vt[10] = '{CSR_READ,  12'h301, 32'h0,          32'h4000_0100, 1'b0};
    vt[11] = '{CSR_NONE,  12'h7C0, 32'h0,          32'h4000_0100, 1'b0};
    vt[12] = '{3'd7,      12'h7C0, 32'h0,          32'h4000_0100, 1'b0};
    vt[13] = '{CSR_WRITE, 12'h305, 32'hFFFF_FFFF,  32'h0000_0000, 1'b0};
    vt[14] = '{CSR_READ,  12'h305, 32'h0,          32'hFFFF_FFFD, 1'b0};
    vt[15] = '{CSR_WRITE, 12'h341, 32'h1234_5677,  32'h0000_0000, 1'b0};
    vt[16] = '{CSR_READ,  12'h341, 32'h0,          32'h1234_5674, 1'b0};
    vt[17] = '{CSR_WRITE, 12'h304, 32'hFFFF_FFFF,  32'h0000_0000, 1'b0};
    vt[18] = '{CSR_READ,  12'h304, 32'h0,          32'h0000_0888, 1'b0};
    vt[19] = '{CSR_WRITE, 12'h300, 32'hFFFF_FFFF,  32'h0000_1800, 1'b0};
    vt[20] = '{CSR_READ,  12'h300, 32'h0,          32'h0000_1888, 1'b0};
    vt[21] = '{CSR_WRITE, 12'h301, 32'h0,          32'h4000_0100, 1'b0};
    vt[22] = '{CSR_WRITE, 12'hF14, 32'h1,          32'h0000_0000, 1'b1};

    bus.csr_op = 0; bus.csr_addr = 0; bus.csr_din = 0;
    retire = 0; trap = 0; mret = 0;
    trap_cause = 0; trap_pc = 0; trap_val = 0;
    irq_ext = 0; irq_timer = 0; irq_soft = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 23; i++) begin
      step(vt[i].op, vt[i].addr, vt[i].din);
      chk($sformatf("vec%0d dout", i),    bus.csr_dout,            vt[i].exp_dout);
      chk($sformatf("vec%0d illegal", i), {31'd0, bus.csr_illegal}, {31'd0, vt[i].exp_ill});
    end

    // Counter carry across the 32-bit boundary, then hi write without carry
    step(CSR_WRITE, 12'hB00, 32'hFFFF_FFFE);
    step(CSR_NONE,  12'h000, 32'h0);
    step(CSR_NONE,  12'h000, 32'h0);
    step(CSR_READ,  12'hB00, 32'h0);  chk("mcycle after carry",  bus.csr_dout, 32'h0);
    step(CSR_READ,  12'hB80, 32'h0);  chk("mcycleh after carry", bus.csr_dout, 32'h1);
    step(CSR_WRITE, 12'hB00, 32'hFFFF_FFFF);
    step(CSR_WRITE, 12'hB80, 32'h0000_AAAA);
    step(CSR_READ,  12'hB00, 32'h0);  chk("mcycle held on hi write", bus.csr_dout, 32'hFFFF_FFFF);
    step(CSR_READ,  12'hB80, 32'h0);  chk("mcycleh written", bus.csr_dout, 32'h0000_AAAB);
    step(CSR_READ,  12'hC80, 32'h0);  chk("cycleh shadow",   bus.csr_dout, 32'h0000_AAAB);
    retire = 1;
    step(CSR_WRITE, 12'hB82, 32'h1234);
    chk("minstreth write legal", {31'd0, bus.csr_illegal}, 32'd0);
    step(CSR_READ,  12'hC02, 32'h0);
    chk("instret read legal", {31'd0, bus.csr_illegal}, 32'd0);
    retire = 0;

    // Interrupt pending, trap entry, mret
    step(CSR_WRITE, 12'h300, 32'h8);
    irq_ext = 1;
    step(CSR_WRITE, 12'h304, 32'h800);
    chk("irq_pending armed", {31'd0, irq_pending}, 32'd1);
    trap = 1; trap_pc = 32'h1003; trap_cause = 32'h8000_000B; trap_val = 32'hCAFE;
    step(CSR_NONE, 12'h000, 32'h0);
    trap = 0;
    chk("mepc on trap", mepc_o, 32'h1000);
    chk("irq masked after trap", {31'd0, irq_pending}, 32'd0);
    step(CSR_READ, 12'h300, 32'h0);  chk("mstatus after trap", bus.csr_dout, 32'h1880);
    step(CSR_READ, 12'h342, 32'h0);  chk("mcause", bus.csr_dout, 32'h8000_000B);
    step(CSR_READ, 12'h343, 32'h0);  chk("mtval",  bus.csr_dout, 32'hCAFE);
    mret = 1;
    step(CSR_NONE, 12'h000, 32'h0);
    mret = 0;
    step(CSR_READ, 12'h300, 32'h0);  chk("mstatus after mret", bus.csr_dout, 32'h1888);
    chk("irq after mret", {31'd0, irq_pending}, 32'd1);

    // Trap overrides mepc write; trap beats mret; other CSR writes commit
    trap = 1; trap_pc = 32'h2006;
    step(CSR_WRITE, 12'h341, 32'h55);
    trap = 0;
    chk("trap beats mepc write", mepc_o, 32'h2004);
    trap = 1; mret = 1; trap_pc = 32'h3000;
    step(CSR_WRITE, 12'h340, 32'h77);
    trap = 0; mret = 0;
    step(CSR_READ, 12'h340, 32'h0);  chk("mscratch during trap", bus.csr_dout, 32'h77);
    step(CSR_READ, 12'h300, 32'h0);  chk("trap beats mret", bus.csr_dout, 32'h1800);
    mret = 1;
    step(CSR_WRITE, 12'h300, 32'h8);
    mret = 0;
    step(CSR_READ, 12'h300, 32'h0);  chk("mret beats mstatus write", bus.csr_dout, 32'h1880);
    mret = 1;
    step(CSR_NONE, 12'h000, 32'h0);
    mret = 0;
    chk("irq before reset", {31'd0, irq_pending}, 32'd1);
    step(CSR_READ, 12'h301, 32'h0);

    // Reset mid-operation
    bus.csr_op = CSR_READ; bus.csr_addr = 12'h305;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    bus.csr_op = CSR_NONE;
    @(posedge clk);
    #1 chk("midreset discard", bus.csr_dout, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  rop;
      logic [11:0] ra;
      rop    = 3'($urandom_range(0, 7));
      ra     = addr_pool[$urandom_range(0, 21)];
      retire = 1'($urandom_range(0, 1));
      trap   = ($urandom_range(0, 7) == 0);
      mret   = ($urandom_range(0, 7) == 0);
      trap_pc = $urandom; trap_cause = $urandom; trap_val = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        irq_ext   = 1'($urandom_range(0, 1));
        irq_timer = 1'($urandom_range(0, 1));
        irq_soft  = 1'($urandom_range(0, 1));
      end
      step(rop, ra, $urandom);
    end
    trap = 0; mret = 0; retire = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
